// File: rtl/dmem_loader.sv
// dmem_loader: byte-stream loader in front of the data memory.
//
// Receives a 16-bit big-endian length N (in words) followed by N words of
// bytes, packs each DATA_W/8 bytes MSB-first into a word and writes them to
// consecutive dmem locations from word 0. Outside a load the CPU port is
// passed straight through to dmem; during a load the loader owns dmem and
// holds the CPU with cpu_stall.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle load request (IDLE/DONE only)
//   in_data/in_valid      byte stream input
//   in_ready              loader accepts a byte this cycle
//   cpu_a/cpu_wd/cpu_we   CPU data-memory request
//   cpu_rd                CPU read data (always mem_rd)
//   mem_a/mem_wd/mem_we   dmem request
//   mem_rd                dmem read data
//   cpu_stall             a load owns dmem
//   done                  load finished (DONE state)
//   err                   sticky: a word fell at index >= DEPTH and was dropped
module dmem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rd,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);

  localparam int BPW = DATA_W / 8;
  localparam logic [7:0] LAST_BYTE = 8'(BPW - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_FLUSH, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic              wr_pend_q, wr_pend_d;
  logic              wr_ok_q, wr_ok_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              loading;
  logic              accept;
  logic              in_range;
  logic [DATA_W-1:0] packed_word;

  assign loading  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_FLUSH);
  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA);
  assign accept   = in_valid && in_ready;
  assign in_range = {1'b0, word_idx_q} < DEPTH_L;
  // New byte enters at the bottom so the first byte of a word ends up in the MSB.
  assign packed_word = (pack_q << 8) | DATA_W'(in_data);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    word_idx_d = word_idx_q;
    pack_d     = pack_q;
    wr_pend_d  = 1'b0;
    wr_ok_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          word_idx_d = '0;
          pack_d     = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          if ({len_q[15:8], in_data} == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          pack_d = packed_word;
          if (byte_cnt_q == LAST_BYTE) begin
            // Word complete: stage it for the write on the next cycle while
            // the packer keeps accepting bytes of the following word.
            byte_cnt_d = '0;
            wr_pend_d  = 1'b1;
            wr_ok_d    = in_range;
            wr_addr_d  = word_idx_q;
            wr_data_d  = packed_word;
            if (!in_range) err_d = 1'b1;
            word_idx_d = word_idx_q + ADDR_W'(1);
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == len_q - 16'd1) state_d = S_FLUSH;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      word_idx_q <= '0;
      pack_q     <= '0;
      wr_pend_q  <= 1'b0;
      wr_ok_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_idx_q <= word_idx_d;
      pack_q     <= pack_d;
      wr_pend_q  <= wr_pend_d;
      wr_ok_q    <= wr_ok_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // dmem port mux: loader owns memory during a load, CPU otherwise.
  assign mem_a     = loading ? wr_addr_q : cpu_a;
  assign mem_wd    = loading ? wr_data_q : cpu_wd;
  assign mem_we    = loading ? (wr_pend_q && wr_ok_q) : cpu_we;
  assign cpu_rd    = mem_rd;
  assign cpu_stall = loading;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_loader.sv
module tb_dmem_loader;

  logic        clk = 1'b0;
  logic        rst, start, start4, in_valid, sel4, mem_clr;
  logic [7:0]  in_data;
  logic [15:0] cpu_a;
  logic [31:0] cpu_wd;
  logic        cpu_we;

  logic        in_ready, mem_we, cpu_stall, done, err;
  logic [31:0] cpu_rd, mem_wd, mem_rd;
  logic [15:0] mem_a;
  logic        in_ready4, mem_we4, cpu_stall4, done4, err4;
  logic [31:0] cpu_rd4, mem_wd4, mem_rd4;
  logic [15:0] mem_a4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit stuck;

  logic [31:0] mem  [256];
  logic [31:0] mem4 [8];
  logic [15:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          wr_c[$];
  logic [15:0] wr4_a[$];
  logic [31:0] wr4_d[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_loader #(.DATA_W(32), .ADDR_W(16), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cpu_a(cpu_a), .cpu_wd(cpu_wd), .cpu_we(cpu_we),
    .cpu_rd(cpu_rd), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd), .cpu_stall(cpu_stall), .done(done), .err(err));

  dmem_loader #(.DATA_W(32), .ADDR_W(16), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready4), .cpu_a(cpu_a), .cpu_wd(cpu_wd), .cpu_we(cpu_we),
    .cpu_rd(cpu_rd4), .mem_a(mem_a4), .mem_wd(mem_wd4), .mem_we(mem_we4),
    .mem_rd(mem_rd4), .cpu_stall(cpu_stall4), .done(done4), .err(err4));

  // Memory models
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      for (int i = 0; i < 8; i++) mem4[i] <= 32'h0;
    end else begin
      if (mem_we)  mem[mem_a[7:0]]  <= mem_wd;
      if (mem_we4) mem4[mem_a4[2:0]] <= mem_wd4;
    end
  end
  assign mem_rd  = mem[mem_a[7:0]];
  assign mem_rd4 = mem4[mem_a4[2:0]];

  // Write logger (loader-originated writes only)
  always @(negedge clk) begin
    if (mem_we && cpu_stall) begin
      wr_a.push_back(mem_a); wr_d.push_back(mem_wd); wr_c.push_back(cyc);
    end
    if (mem_we4 && cpu_stall4) begin
      wr4_a.push_back(mem_a4); wr4_d.push_back(mem_wd4);
    end
  end

  task automatic pulse_start(input bit four, output int s);
    if (four) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    while (!(sel4 ? in_ready4 : in_ready) && n < 20) begin
      @(negedge clk); n++;
    end
    if (!(sel4 ? in_ready4 : in_ready)) stuck = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit four, output int dc);
    dc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((four ? done4 : done) === 1'b1) begin dc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    cpu_we = 1'b1; cpu_a = 16'd3; cpu_wd = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL pt_mem_we got %b want 1", mem_we); end
    checks++; if (mem_a !== 16'd3) begin errors++; $display("FAIL pt_mem_a got %h want 0003", mem_a); end
    checks++; if (mem_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL pt_mem_wd got %h want deadbeef", mem_wd); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL pt_stall got %b want 0", cpu_stall); end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(negedge clk);
    checks++; if (cpu_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL pt_read got %h want deadbeef", cpu_rd); end
    cpu_a = 16'd0; cpu_wd = 32'h0;
  endtask

  task automatic test_load(input bit gap);
    logic [7:0] b [10];
    int s, a, dc, e_w0, e_w1, e_dn;
    b = '{8'h00, 8'h02, 8'h08, 8'h0E, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04};
    e_w0 = gap ? 12 : 7;
    e_w1 = gap ? 20 : 11;
    e_dn = gap ? 21 : 12;
    wr_a.delete(); wr_d.delete(); wr_c.delete(); stuck = 1'b0;
    pulse_start(1'b0, s);
    for (int i = 0; i < 10; i++) begin
      send_byte(b[i], a);
      if (gap) begin @(posedge clk); #1; end
    end
    wait_done(1'b0, dc);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL load%0d_ready got stuck want accepting", gap); end
    checks++; if (dc - s !== e_dn) begin errors++; $display("FAIL load%0d_done_time got %0d want %0d", gap, dc - s, e_dn); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL load%0d_stall got %b want 0", gap, cpu_stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL load%0d_err got %b want 0", gap, err); end
    checks++;
    if (wr_a.size() != 2) begin
      errors++; $display("FAIL load%0d_nwrites got %0d want 2", gap, wr_a.size());
    end else begin
      checks++; if (wr_a[0] !== 16'd0 || wr_d[0] !== 32'h080E0001) begin errors++; $display("FAIL load%0d_w0 got %h@%h want 080e0001@0000", gap, wr_d[0], wr_a[0]); end
      checks++; if (wr_a[1] !== 16'd1 || wr_d[1] !== 32'h00020004) begin errors++; $display("FAIL load%0d_w1 got %h@%h want 00020004@0001", gap, wr_d[1], wr_a[1]); end
      checks++; if (wr_c[0] - s !== e_w0) begin errors++; $display("FAIL load%0d_w0_time got %0d want %0d", gap, wr_c[0] - s, e_w0); end
      checks++; if (wr_c[1] - s !== e_w1) begin errors++; $display("FAIL load%0d_w1_time got %0d want %0d", gap, wr_c[1] - s, e_w1); end
    end
    cpu_a = 16'd0; #1;
    checks++; if (cpu_rd !== 32'h080E0001) begin errors++; $display("FAIL load%0d_rd0 got %h want 080e0001", gap, cpu_rd); end
    cpu_a = 16'd1; #1;
    checks++; if (cpu_rd !== 32'h00020004) begin errors++; $display("FAIL load%0d_rd1 got %h want 00020004", gap, cpu_rd); end
    cpu_a = 16'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_n0();
    int s, a;
    wr_a.delete(); wr_d.delete(); wr_c.delete(); stuck = 1'b0;
    pulse_start(1'b0, s);
    send_byte(8'h00, a);
    send_byte(8'h00, a);
    @(negedge clk);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL n0_ready got stuck want accepting"); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL n0_done got %b want 1", done); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL n0_stall got %b want 0", cpu_stall); end
    checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL n0_nwrites got %0d want 0", wr_a.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_in_done();
    start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sid_ready_done got %b want 0", in_ready); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || cpu_stall !== 1'b1) begin errors++; $display("FAIL sid_len_hi got ready=%b stall=%b want 1 1", in_ready, cpu_stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sid_done_clr got %b want 0", done); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || cpu_stall !== 1'b1) begin errors++; $display("FAIL sid_len_lo got ready=%b stall=%b want 1 1", in_ready, cpu_stall); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sid_done got %b want 1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_depth();
    logic [31:0] ew [4];
    int s, a, dc;
    ew = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    sel4 = 1'b1; stuck = 1'b0;
    wr4_a.delete(); wr4_d.delete();
    pulse_start(1'b1, s);
    send_byte(8'h00, a);
    send_byte(8'h05, a);
    for (int i = 0; i < 20; i++) send_byte(8'(i), a);
    wait_done(1'b1, dc);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL depth_ready got stuck want accepting"); end
    checks++; if (dc - s !== 24) begin errors++; $display("FAIL depth_done_time got %0d want 24", dc - s); end
    checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL depth_err got %b want 1", err4); end
    checks++; if (cpu_stall4 !== 1'b0) begin errors++; $display("FAIL depth_stall got %b want 0", cpu_stall4); end
    checks++; if (mem4[4] !== 32'h0) begin errors++; $display("FAIL depth_word4 got %h want 00000000", mem4[4]); end
    checks++;
    if (wr4_a.size() != 4) begin
      errors++; $display("FAIL depth_nwrites got %0d want 4", wr4_a.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (wr4_a[j] !== 16'(j) || wr4_d[j] !== ew[j]) begin
          errors++; $display("FAIL depth_w%0d got %h@%h want %h@%h", j, wr4_d[j], wr4_a[j], ew[j], 16'(j));
        end
      end
    end
    sel4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int s, a, dc;
    wr_a.delete(); wr_d.delete(); wr_c.delete(); stuck = 1'b0;
    pulse_start(1'b0, s);
    send_byte(8'h00, a);
    send_byte(8'h03, a);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), a);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b want 0", cpu_stall); end
    checks++; if (in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_idle got ready=%b done=%b want 0 0", in_ready, done); end
    checks++; if (mem_we !== cpu_we) begin errors++; $display("FAIL rmid_mem_we got %b want %b", mem_we, cpu_we); end
    checks++;
    if (wr_a.size() != 1) begin
      errors++; $display("FAIL rmid_nwrites got %0d want 1", wr_a.size());
    end else begin
      checks++; if (wr_a[0] !== 16'd0 || wr_d[0] !== 32'h01020304) begin errors++; $display("FAIL rmid_w0 got %h@%h want 01020304@0000", wr_d[0], wr_a[0]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    pulse_start(1'b0, s);
    send_byte(8'h00, a);
    send_byte(8'h01, a);
    send_byte(8'hAA, a);
    send_byte(8'hBB, a);
    send_byte(8'hCC, a);
    send_byte(8'hDD, a);
    wait_done(1'b0, dc);
    checks++; if (stuck !== 1'b0 || dc < 0) begin errors++; $display("FAIL restart_progress got stuck=%b done_cyc=%0d want accepting and done", stuck, dc); end
    checks++;
    if (wr_a.size() != 1) begin
      errors++; $display("FAIL restart_nwrites got %0d want 1", wr_a.size());
    end else begin
      checks++; if (wr_a[0] !== 16'd0 || wr_d[0] !== 32'hAABBCCDD) begin errors++; $display("FAIL restart_w0 got %h@%h want aabbccdd@0000", wr_d[0], wr_a[0]); end
    end
    cpu_a = 16'd0; #1;
    checks++; if (cpu_rd !== 32'hAABBCCDD) begin errors++; $display("FAIL restart_rd0 got %h want aabbccdd", cpu_rd); end
    cpu_a = 16'd1; #1;
    checks++; if (cpu_rd !== 32'h01020304 && cpu_rd !== 32'h00020004) begin errors++; $display("FAIL restart_rd1 got %h want untouched word", cpu_rd); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_a = 16'd0; cpu_wd = 32'h0; cpu_we = 1'b0; sel4 = 1'b0; mem_clr = 1'b1; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    test_reset();
    test_passthrough();
    test_load(1'b0);
    test_load(1'b1);
    test_n0();
    test_start_in_done();
    test_depth();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_loader.md
# dmem_loader

Byte-stream loader that sits directly upstream of the data memory `dmem`. It receives a length-prefixed byte stream over a valid/ready handshake, packs bytes big-endian into `DATA_W`-bit words and writes them into consecutive `dmem` locations starting at word 0. While the loader is idle or done, it passes CPU data-memory accesses straight through to `dmem`. During a load it owns the `dmem` port and holds the CPU with `cpu_stall`.

## Interface
- `DATA_W`, 32: word width; must equal the `dmem` data width; a multiple of 8.
- `ADDR_W`, 16: `dmem` address width.
- `DEPTH`, 256: number of `dmem` words; writes at index >= `DEPTH` are suppressed.

Ports (width, meaning):
- `clk` (input, 1): rising-edge clock.
- `rst` (input, 1): reset, asynchronous, active-high.
- `start` (input, 1): one-cycle request to begin a load; honoured only in IDLE or DONE.
- `in_data` (input, 8): stream byte.
- `in_valid` (input, 1): `in_data` is valid.
- `in_ready` (output, 1): loader accepts a byte this cycle.
- `cpu_a` (input, `ADDR_W`): CPU word address.
- `cpu_wd` (input, `DATA_W`): CPU write data.
- `cpu_we` (input, 1): CPU write enable.
- `cpu_rd` (output, `DATA_W`): equals `mem_rd`, combinational and always passed through.
- `mem_a` (output, `ADDR_W`): to `dmem` `a`.
- `mem_wd` (output, `DATA_W`): to `dmem` `wd`.
- `mem_we` (output, 1): to `dmem` `we`.
- `mem_rd` (input, `DATA_W`): from `dmem` `rd`.
- `cpu_stall` (output, 1): high while a load owns memory.
- `done` (output, 1): high in DONE.
- `err` (output, 1): sticky; a word was dropped because its index was >= `DEPTH`.

## Operation
- States are IDLE, LEN_HI, LEN_LO, DATA, FLUSH and DONE.
- Accept means `in_valid && in_ready`. `in_ready` = 1 only in LEN_HI, LEN_LO and DATA.
- IDLE or DONE with `start` = 1: go to LEN_HI, clear `err` and `done`, and reset the byte counter and word index to 0.
- LEN_HI, on accept: latch `N[15:8]`, then go to LEN_LO.
- LEN_LO, on accept: latch `N[7:0]`.
  - If N = 0, go to DONE.
  - Otherwise go to DATA.
- DATA: each accepted byte shifts into the packing register, with the first byte landing in the MSB.
  - When the (DATA_W/8)-th byte of a word is accepted, the next cycle asserts `mem_we` with the packed word at `mem_a` = word index, and the word index then increments.
  - If that byte completes word N-1, go to FLUSH. Otherwise stay in DATA; byte acceptance continues during the write cycle.
- FLUSH: the final write occurs (`mem_we` = 1 for one cycle), then go to DONE.
- Index >= `DEPTH`: `mem_we` is forced to 0 for that write and `err` is set. Bytes are still consumed and the count still advances.
- Mux:
  - In LEN_HI, LEN_LO, DATA and FLUSH, `mem_a`/`mem_wd`/`mem_we` come from the loader (`mem_we` = 0 except on write cycles) and `cpu_stall` = 1.
  - In IDLE and DONE, `mem_*` = `cpu_*` and `cpu_stall` = 0.
- `start` in LEN_HI, LEN_LO, DATA or FLUSH is ignored.
- `in_valid` in IDLE, DONE or FLUSH is not accepted, and no bytes are dropped silently.

## Timing
- Reset values: state IDLE; N, counters and the packing register = 0.
  - Registered outputs: `done` = 0, `err` = 0.
  - State-derived outputs: `cpu_stall` = 0, `in_ready` = 0.
  - In IDLE, `mem_*` follow `cpu_*` combinationally (so `mem_we` = `cpu_we`).
- Reset mid-load: immediate return to IDLE. Partially packed words are discarded and no further writes occur. Words already written remain in `dmem`.
- Write latency: `mem_we` is high exactly 1 cycle after the accept of the last byte of each word.
- Throughput: 1 byte per cycle sustained.
  - A load of N words with continuous `in_valid` takes 2 + 4N cycles of accepts, then FLUSH (1 cycle), then DONE.
  - `done` goes high 2 cycles after the final byte accept.
- `in_valid` gaps stall the FSM without losing state.
- `start` and a byte present in the same cycle in DONE: only the state transition happens; the byte is accepted from the next cycle (LEN_HI).
- The word index wraps at 2^`ADDR_W`; N ≤ 65535 keeps the index within 16 bits.

## Test plan
- Reset, then CPU pass-through: `cpu_we` = 1, `cpu_a` = 3, `cpu_wd` = 0xDEADBEEF.
  - Expect `mem_we` = 1, `mem_a` = 3 and `cpu_stall` = 0.
  - A read of address 3 returns 0xDEADBEEF on `cpu_rd`.
- Load N = 2 with bytes 08 0E 00 01 00 02 00 04 streamed with no gaps.
  - Expect writes of 0x080E0001 to address 0 and 0x00020004 to address 1, each 1 cycle after the 4th byte.
  - Expect `done` = 1, `cpu_stall` = 0 and `err` = 0 at the end.
- Same load with `in_valid` toggling 1/0 each cycle: identical writes and contents, and `done` is delayed accordingly.
- N = 0 (bytes 00 00): DONE directly after LEN_LO, no `mem_we` pulse, `done` = 1.
- With `DEPTH` = 4, load N = 5: addresses 0–3 are written, the 5th word is not written, `err` = 1 and `done` = 1.
- Assert `rst` after the 6th data byte of N = 3:
  - State returns to IDLE with `cpu_stall` = 0, and only word 0 has been written.
  - A subsequent `start` restarts cleanly at index 0.
